pass_regbank: RTL and testbench
===============================

# pass_regbank

Parametrised AXI4-Lite slave register bank, the next generation of the fixed four-register `pass` peripheral in the DFX design. It exposes `NUM_REGS` read/write registers of `DATA_WIDTH` bits to the fabric and adds byte strobes, per-register write pulses, out-of-range decoding and a DFX decouple input. AW and W are accepted independently. It sits behind the static-region AXI interconnect, one instance per reconfigurable partition.

## Interface
- `NUM_REGS`, 4: number of registers, range 1–256.
- `DATA_WIDTH`, 32: register and bus width, 32 or 64.
- `ADDR_WIDTH`, 8: AXI address width; must satisfy `2^ADDR_WIDTH >= NUM_REGS*DATA_WIDTH/8`.
- `RESET_VALUE`, 0: reset value of every register.

Ports:
- `ACLK` in 1: clock.
- `ARESETN` in 1: reset, asynchronous, active-low.
- `s_axi_awaddr` in `ADDR_WIDTH`; `s_axi_awprot` in 3 (ignored); `s_axi_awvalid` in 1; `s_axi_awready` out 1.
- `s_axi_wdata` in `DATA_WIDTH`; `s_axi_wstrb` in `DATA_WIDTH/8`; `s_axi_wvalid` in 1; `s_axi_wready` out 1.
- `s_axi_bresp` out 2; `s_axi_bvalid` out 1; `s_axi_bready` in 1.
- `s_axi_araddr` in `ADDR_WIDTH`; `s_axi_arprot` in 3 (ignored); `s_axi_arvalid` in 1; `s_axi_arready` out 1.
- `s_axi_rdata` out `DATA_WIDTH`; `s_axi_rresp` out 2; `s_axi_rvalid` out 1; `s_axi_rready` in 1.
- `decouple` in 1: when high, no new AW/AR is accepted.
- `reg_q` out `NUM_REGS*DATA_WIDTH`: register contents. Register i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `reg_wr_pulse` out `NUM_REGS`: one-cycle pulse per committed write.

## Operation
- **Decode:**
  - Register index = `addr >> log2(DATA_WIDTH/8)`; unaligned low bits are ignored.
  - Index `>= NUM_REGS` is out of range.
- **Write path:** AW and W each have a one-entry hold flop.
  - `awready = en & !aw_held & !bvalid & !decouple`.
  - `wready = en & !w_held & !bvalid`.
  - Commit condition: `(aw_held|aw_hs) & (w_held|w_hs) & !bvalid`.
  - On commit, bytes with `wstrb=1` update the addressed register, `bvalid` sets, and both holds clear.
  - `bvalid` holds with `bresp` stable until `bready`.
- **Read path:**
  - `arready = en & !rvalid & !decouple`.
  - On AR handshake, `rdata`/`rresp` are captured from current register contents and `rvalid` sets.
  - Both hold until `rready`.
- **Reset-release enable:** `en` is a flop cleared by reset and set on the first `ACLK` edge after `ARESETN` rises. All readies are gated by `en`.
- **Write pulse:** `reg_wr_pulse[i]` is high for exactly the cycle after an in-range commit to register i, coincident with `bvalid` rising. It fires even when `wstrb=0`.
- **Decouple:**
  - W already in flight, held AW/W and pending B/R complete normally; only AW and AR acceptance stop.
  - Raising `decouple` in the same cycle as `awvalid` blocks that AW.
- **Reset values:** all readies 0, `bvalid`/`rvalid` 0, `bresp`/`rresp` 2'b00, `rdata` 0, every register `RESET_VALUE`, `reg_wr_pulse` 0.
- **Reset mid-transaction:** holds and pending responses are discarded, registers return to `RESET_VALUE`, no pulse is emitted.

## Timing
- **Write latency:** `bvalid` rises 1 cycle after the later of the AW and W handshakes; same-cycle AW+W gives 1 cycle.
- **Read latency:** `rvalid` rises 1 cycle after the AR handshake.
- **Throughput:** one write per 2 cycles with `bready` tied high (readies drop while `bvalid` is high). Reads likewise one per 2 cycles.
- **Read/write collision:** AR handshake on the same edge as a write commit to the same register returns the pre-write value.
- Read and write paths are fully independent; concurrent traffic is allowed.
- `reg_q` reflects a commit 1 cycle after the commit edge.

## Configuration
- `PASS_REGBANK_SLVERR_EN` defined:
  - Out-of-range write returns `bresp`=2'b10 (SLVERR); registers are unchanged and no pulse fires.
  - Out-of-range read returns `rresp`=2'b10 with `rdata`=0.
- `PASS_REGBANK_SLVERR_EN` undefined:
  - Out-of-range accesses return OKAY (2'b00).
  - Writes are dropped and reads return 0.

## Test plan
- **Reset:** hold `ARESETN` low 200 ns, release → all readies are 0 on the first edge and 1 from the second; reads of regs 0–3 return 0 with OKAY.
- **Sequential write/read:** write 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then read back → data matches, all resp OKAY, `reg_wr_pulse` fires once per register in order.
- **Byte strobes:** reg0 = 0x00000001; write 0xAABBCCDD with `wstrb`=4'b0010 → reg0 reads 0x0000CC01.
- **Decoupled AW/W:** W is presented 3 cycles before AW → `wready` drops after W is accepted; `bvalid` rises 1 cycle after the AW handshake. Hold `bready` low for 4 cycles → `awready` stays 0 and `bresp` stays stable.
- **Out-of-range access:** with `NUM_REGS`=4, write then read at 0x10 → with the macro, SLVERR/`rdata` 0; without it, OKAY/0; `reg_q` unchanged in both builds.
- **Decouple and collision:**
  - Assert `decouple` while `rvalid` is pending and `rready` is low → the R beat completes and `arready` stays 0 until `decouple` falls.
  - Read reg1 (value 2) on the same edge as a write of 7 to reg1 commits → returns 2.

Source files
------------

// File: rtl/pass_regbank_if.sv
// AXI4-Lite bundle between the static-region interconnect and pass_regbank.
// Signal names drop the s_axi_ prefix; the interface instance carries it.
interface pass_regbank_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/pass_regbank.sv
// Parametrised AXI4-Lite register bank with byte strobes, write pulses and DFX decouple.
// Define PASS_REGBANK_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module pass_regbank #(
    parameter int                    NUM_REGS    = 4,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    pass_regbank_if.slave                  s_axi,
    input  logic                           decouple,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr_pulse
);

    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);

    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef PASS_REGBANK_SLVERR_EN
    localparam logic [1:0] RESP_OOR  = 2'b10;
`else
    localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

    logic                  en_q, en_d;
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_W-1:0]     w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [NUM_REGS-1:0]   pulse_q, pulse_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  awready, wready, arready;
    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr, wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]     wr_strb;
    logic                  wr_ok, rd_ok;

    always_comb begin
        en_d    = 1'b1;
        awready = en_q & ~aw_held_q & ~bvalid_q & ~decouple;
        wready  = en_q & ~w_held_q & ~bvalid_q;
        arready = en_q & ~rvalid_q & ~decouple;

        aw_hs = s_axi.awvalid & awready;
        w_hs  = s_axi.wvalid & wready;
        ar_hs = s_axi.arvalid & arready;

        // A held beat takes priority; otherwise the beat handshaking this edge is used directly.
        wr_addr = aw_held_q ? aw_addr_q : s_axi.awaddr;
        wr_data = w_held_q ? w_data_q : s_axi.wdata;
        wr_strb = w_held_q ? w_strb_q : s_axi.wstrb;
        wr_idx  = wr_addr >> ADDR_LSB;
        wr_ok   = 32'(wr_idx) < 32'(NUM_REGS);
        commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs) & ~bvalid_q;

        aw_held_d = ~commit & (aw_held_q | aw_hs);
        aw_addr_d = aw_hs ? s_axi.awaddr : aw_addr_q;
        w_held_d  = ~commit & (w_held_q | w_hs);
        w_data_d  = w_hs ? s_axi.wdata : w_data_q;
        w_strb_d  = w_hs ? s_axi.wstrb : w_strb_q;

        regs_d   = regs_q;
        pulse_d  = '0;
        bvalid_d = bvalid_q & ~s_axi.bready;
        bresp_d  = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_ok ? RESP_OKAY : RESP_OOR;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_ok && (32'(wr_idx) == 32'(i))) begin
                    pulse_d[i] = 1'b1;
                    for (int b = 0; b < STRB_W; b++) begin
                        if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                    end
                end
            end
        end

        // Reads sample regs_q, so a same-edge commit is not yet visible.
        rd_idx   = s_axi.araddr >> ADDR_LSB;
        rd_ok    = 32'(rd_idx) < 32'(NUM_REGS);
        rvalid_d = rvalid_q & ~s_axi.rready;
        rresp_d  = rresp_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_ok ? RESP_OKAY : RESP_OOR;
            rdata_d  = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_ok && (32'(rd_idx) == 32'(i))) rdata_d = regs_q[i];
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            en_q      <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            pulse_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
        end else begin
            en_q      <= en_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.arready = arready;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rdata   = rdata_q;
    assign reg_wr_pulse  = pulse_q;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    logic unused_prot;
    assign unused_prot = ^{s_axi.awprot, s_axi.arprot};

endmodule

// File: tb/tb_pass_regbank.sv
// Self-checking bench for pass_regbank (4 x 32-bit registers) against a register-array model.
module tb_pass_regbank;

    logic         ACLK;
    logic         ARESETN;
    logic         decouple;
    logic [127:0] reg_q;
    logic [3:0]   reg_wr_pulse;

    pass_regbank_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

    pass_regbank #(
        .NUM_REGS(4), .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESET_VALUE(32'h0)
    ) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .s_axi(bus),
        .decouple(decouple), .reg_q(reg_q), .reg_wr_pulse(reg_wr_pulse)
    );

`ifdef PASS_REGBANK_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] mdl [4];

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] mask;
        mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    task automatic chk_regs(input string tag);
        for (int i = 0; i < 4; i++) chk_val(tag, reg_q[i*32 +: 32], mdl[i]);
    endtask

    // Entered and left on a falling edge.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        bit         aw_done = 0;
        bit         w_done  = 0;
        int         n       = 0;
        int         idx     = int'(a >> 2);
        bit         ok      = (idx < 4);
        logic [3:0] exp_p   = ok ? 4'(1 << idx) : 4'b0;
        bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            #1;
            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) w_done = 1;
            @(negedge ACLK);
            if (aw_done) bus.awvalid = 1'b0;
            if (w_done) bus.wvalid = 1'b0;
            n++;
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk_val("wr_handshake", {aw_done, w_done}, 2'b11);
        if (ok) mdl[idx] = merge(mdl[idx], d, s);
        #1;
        chk_val("wr_bvalid_lat", bus.bvalid, 1'b1);
        chk_val("wr_bresp", bus.bresp, ok ? 2'b00 : OOR_RESP);
        chk_val("wr_pulse", reg_wr_pulse, exp_p);
        @(negedge ACLK);
        #1;
        chk_val("wr_bvalid_clr", bus.bvalid, 1'b0);
        chk_val("wr_pulse_clr", reg_wr_pulse, 4'b0);
        chk_regs("wr_reg_q");
        @(negedge ACLK);
    endtask

    task automatic axi_read(input logic [7:0] a);
        bit done = 0;
        int n    = 0;
        int idx  = int'(a >> 2);
        bit ok   = (idx < 4);
        bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
        while (!done && n < 20) begin
            #1;
            if (bus.arready) done = 1;
            @(negedge ACLK);
            if (done) bus.arvalid = 1'b0;
            n++;
        end
        bus.arvalid = 1'b0;
        chk_val("rd_handshake", done, 1'b1);
        #1;
        chk_val("rd_rvalid_lat", bus.rvalid, 1'b1);
        chk_val("rd_rdata", bus.rdata, ok ? mdl[idx] : 32'h0);
        chk_val("rd_rresp", bus.rresp, ok ? 2'b00 : OOR_RESP);
        @(negedge ACLK);
    endtask

    initial begin
        logic [7:0] ra;
        ARESETN = 1'b0; decouple = 1'b0;
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;

        // Reset and reset-release enable
        #150;
        chk_val("rst_readies", {bus.awready, bus.wready, bus.arready}, 3'b000);
        chk_val("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
        chk_val("rst_resps", {bus.bresp, bus.rresp}, 4'b0);
        chk_val("rst_rdata", bus.rdata, 32'h0);
        chk_val("rst_pulse", reg_wr_pulse, 4'b0);
        chk_regs("rst_reg_q");
        #50;
        ARESETN = 1'b1;
        #1;
        chk_val("rdy_first", {bus.awready, bus.wready, bus.arready}, 3'b000);
        @(negedge ACLK);
        #1;
        chk_val("rdy_second", {bus.awready, bus.wready, bus.arready}, 3'b111);
        @(negedge ACLK);
        for (int i = 0; i < 4; i++) axi_read(8'(4 * i));

        // Sequential write / read
        for (int i = 0; i < 4; i++) axi_write(8'(4 * i), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) axi_read(8'(4 * i));

        // Byte strobes
        axi_write(8'h00, 32'h0000_0001, 4'hF);
        axi_write(8'h00, 32'hAABB_CCDD, 4'b0010);
        chk_val("strb_reg0", reg_q[31:0], 32'h0000_CC01);
        axi_read(8'h00);

        // W leads AW by 3 cycles, then B is back-pressured
        bus.wdata = 32'h5A5A_1234; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b0;
        #1;
        chk_val("dw_wready", bus.wready, 1'b1);
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        #1;
        chk_val("dw_w_held", bus.wready, 1'b0);
        chk_val("dw_no_b_yet", bus.bvalid, 1'b0);
        @(negedge ACLK);
        @(negedge ACLK);
        bus.awaddr = 8'h08; bus.awvalid = 1'b1;
        #1;
        chk_val("dw_awready", bus.awready, 1'b1);
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        mdl[2] = 32'h5A5A_1234;
        #1;
        chk_val("dw_b_lat", bus.bvalid, 1'b1);
        chk_val("dw_pulse", reg_wr_pulse, 4'b0100);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            #1;
            chk_val("dw_awready_low", bus.awready, 1'b0);
            chk_val("dw_bvalid_hold", bus.bvalid, 1'b1);
            chk_val("dw_bresp_hold", bus.bresp, 2'b00);
        end
        bus.bready = 1'b1;
        @(negedge ACLK);
        #1;
        chk_val("dw_b_done", bus.bvalid, 1'b0);
        chk_regs("dw_reg_q");
        @(negedge ACLK);

        // Out-of-range
        axi_write(8'h10, 32'hDEAD_BEEF, 4'hF);
        axi_read(8'h10);

        // Decouple with a pending R beat
        bus.araddr = 8'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
        #1;
        chk_val("dc_arready", bus.arready, 1'b1);
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        #1;
        chk_val("dc_rvalid", bus.rvalid, 1'b1);
        chk_val("dc_rdata", bus.rdata, mdl[1]);
        decouple = 1'b1; bus.rready = 1'b1;
        @(negedge ACLK);
        bus.araddr = 8'h00; bus.arvalid = 1'b1;
        #1;
        chk_val("dc_r_done", bus.rvalid, 1'b0);
        for (int k = 0; k < 3; k++) begin
            chk_val("dc_arready_low", bus.arready, 1'b0);
            @(negedge ACLK);
            #1;
            chk_val("dc_no_read", bus.rvalid, 1'b0);
        end
        decouple = 1'b0;
        #1;
        chk_val("dc_arready_back", bus.arready, 1'b1);
        @(negedge ACLK);
        bus.arvalid = 1'b0;
        #1;
        chk_val("dc_read_after", bus.rdata, mdl[0]);
        @(negedge ACLK);
        decouple = 1'b1; bus.awaddr = 8'h0C; bus.awvalid = 1'b1;
        #1;
        chk_val("dc_same_cycle_aw", bus.awready, 1'b0);
        @(negedge ACLK);
        decouple = 1'b0; bus.awvalid = 1'b0;
        #1;
        chk_val("dc_aw_not_held", bus.awready, 1'b1);
        @(negedge ACLK);

        // Read of reg1 on the same edge as a write commit to reg1
        bus.wdata = 32'd7; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
        #1;
        chk_val("col_wready", bus.wready, 1'b1);
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        bus.awaddr = 8'h04; bus.awvalid = 1'b1;
        bus.araddr = 8'h04; bus.arvalid = 1'b1; bus.rready = 1'b1;
        #1;
        chk_val("col_readies", {bus.awready, bus.arready}, 2'b11);
        @(negedge ACLK);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        #1;
        chk_val("col_old_value", bus.rdata, mdl[1]);
        chk_val("col_bvalid", bus.bvalid, 1'b1);
        mdl[1] = 32'd7;
        @(negedge ACLK);
        #1;
        chk_regs("col_reg_q");
        @(negedge ACLK);
        axi_read(8'h04);

        // Randomised traffic, including unaligned and out-of-range addresses
        for (int k = 0; k < 60; k++) begin
            ra = 8'($urandom_range(0, 19));
            if ($urandom_range(0, 1) == 1) axi_write(ra, $urandom, 4'($urandom));
            else axi_read(ra);
            repeat ($urandom_range(0, 2)) @(negedge ACLK);
        end

        // Reset with a held W discards it
        bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        @(negedge ACLK);
        bus.wvalid = 1'b0;
        #2;
        ARESETN = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        #1;
        chk_regs("mid_rst_reg_q");
        chk_val("mid_rst_b", {bus.bvalid, reg_wr_pulse}, 5'b0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        @(negedge ACLK);
        bus.awaddr = 8'h00; bus.awvalid = 1'b1;
        #1;
        chk_val("mid_rst_awready", bus.awready, 1'b1);
        @(negedge ACLK);
        bus.awvalid = 1'b0;
        #1;
        chk_val("mid_rst_no_commit", bus.bvalid, 1'b0);
        chk_val("mid_rst_w_dropped", bus.wready, 1'b1);
        chk_val("mid_rst_no_pulse", reg_wr_pulse, 4'b0);
        chk_regs("mid_rst_regs_after");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
